// File: rtl/mem_pkg.sv
// Shared defaults and the port-select type for the two-requester RAM port arbiter.
package mem_pkg;

  localparam int unsigned MEM_ADDR_W       = 10;
  localparam int unsigned MEM_DATA_W       = 32;
  localparam int unsigned MEM_STARVE_LIMIT = 4;
  localparam int unsigned STARVE_CNT_W     = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_I    = 2'd1,
    SEL_D    = 2'd2
  } sel_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, MEM-stage and RAM-side signals of the arbiter bundled as one interface.
interface mem_port_arbiter_if #(
  parameter int unsigned AddrW = 10,
  parameter int unsigned DataW = 32
);

  logic             i_req;
  logic [AddrW-1:0] i_addr;
  logic             i_gnt;
  logic             i_rvalid;
  logic [DataW-1:0] i_rdata;

  logic             d_req;
  logic             d_we;
  logic [AddrW-1:0] d_addr;
  logic [DataW-1:0] d_wdata;
  logic             d_gnt;
  logic             d_rvalid;
  logic [DataW-1:0] d_rdata;

  logic             ram_write_enable;
  logic             ram_read_enable;
  logic [AddrW-1:0] ram_addr;
  logic [DataW-1:0] ram_write_data;
  logic [DataW-1:0] ram_read_data;

  // Arbiter side.
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_read_data,
    output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    output ram_write_enable, ram_read_enable, ram_addr, ram_write_data
  );

  // Requesters plus RAM.
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, ram_read_data,
    input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
    input  ram_write_enable, ram_read_enable, ram_addr, ram_write_data
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant selection: MEM stage wins conflicts unless fetch has starved long enough.
module mem_arb_pick
  import mem_pkg::*;
#(
  parameter int unsigned StarveLimit = MEM_STARVE_LIMIT
) (
  input  logic                    i_req_i,
  input  logic                    d_req_i,
  input  logic [STARVE_CNT_W-1:0] starve_cnt_i,
  output sel_e                    sel_o
);

  always_comb begin
    sel_o = SEL_NONE;
    unique case ({i_req_i, d_req_i})
      2'b10:   sel_o = SEL_I;
      2'b01:   sel_o = SEL_D;
      2'b11:   sel_o = (starve_cnt_i == STARVE_CNT_W'(StarveLimit)) ? SEL_I : SEL_D;
      default: sel_o = SEL_NONE;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter in front of a single-port RAM with registered read responses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W       = MEM_ADDR_W,
  parameter int unsigned DATA_W       = MEM_DATA_W,
  parameter int unsigned STARVE_LIMIT = MEM_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave bus
);

  sel_e                    pick_sel;
  sel_e                    sel;
  logic [STARVE_CNT_W-1:0] starve_cnt_d, starve_cnt_q;
  logic                    i_rvalid_d, i_rvalid_q;
  logic                    d_rvalid_d, d_rvalid_q;
  logic [DATA_W-1:0]       i_rdata_d, i_rdata_q;
  logic [DATA_W-1:0]       d_rdata_d, d_rdata_q;

  mem_arb_pick #(
    .StarveLimit (STARVE_LIMIT)
  ) u_pick (
    .i_req_i      (bus.i_req),
    .d_req_i      (bus.d_req),
    .starve_cnt_i (starve_cnt_q),
    .sel_o        (pick_sel)
  );

  assign sel       = rst ? SEL_NONE : pick_sel;
  assign bus.i_gnt = (sel == SEL_I);
  assign bus.d_gnt = (sel == SEL_D);

  always_comb begin
    bus.ram_write_enable = 1'b0;
    bus.ram_read_enable  = 1'b0;
    bus.ram_addr         = '0;
    bus.ram_write_data   = '0;
    unique case (sel)
      SEL_I: begin
        bus.ram_addr        = bus.i_addr;
        bus.ram_read_enable = 1'b1;
      end
      SEL_D: begin
        bus.ram_addr         = bus.d_addr;
        bus.ram_write_enable = bus.d_we;
        bus.ram_read_enable  = !bus.d_we;
        bus.ram_write_data   = bus.d_we ? bus.d_wdata : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_cnt_d = '0;
    if (bus.i_req && !bus.i_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_CNT_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                                    : starve_cnt_q + 1'b1;
    end
    i_rvalid_d = bus.i_gnt;
    d_rvalid_d = bus.d_gnt && !bus.d_we;
    i_rdata_d  = i_rvalid_d ? bus.ram_read_data : i_rdata_q;
    d_rdata_d  = d_rvalid_d ? bus.ram_read_data : d_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      i_rvalid_q   <= 1'b0;
      d_rvalid_q   <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      i_rvalid_q   <= i_rvalid_d;
      d_rvalid_q   <= d_rvalid_d;
      i_rdata_q    <= i_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Masking with rst drops a response that is still in flight when reset asserts.
  assign bus.i_rvalid = i_rvalid_q && !rst;
  assign bus.d_rvalid = d_rvalid_q && !rst;
  assign bus.i_rdata  = i_rdata_q;
  assign bus.d_rdata  = d_rdata_q;

endmodule
